// File: rtl/reg_file_writeback_arbiter.sv
// reg_file_writeback_arbiter: merges pipeline and buffered long-latency results onto the register file write port.
// Define OPT_WB_L_BYPASS_EN to let port-L results skip an empty FIFO when port A is idle.
module reg_file_writeback_arbiter #(
    parameter int NUM_REGS   = 16,
    parameter int DATA_WIDTH = 32,
    parameter int SEL_WIDTH  = 4,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  a_valid,
    input  logic [SEL_WIDTH-1:0]  a_sel,
    input  logic [DATA_WIDTH-1:0] a_data,
    input  logic                  l_valid,
    output logic                  l_ready,
    input  logic [SEL_WIDTH-1:0]  l_sel,
    input  logic [DATA_WIDTH-1:0] l_data,
    input  logic                  reserve_en,
    input  logic [SEL_WIDTH-1:0]  reserve_sel,
    output logic                  write_en,
    output logic [SEL_WIDTH-1:0]  write_sel,
    output logic [DATA_WIDTH-1:0] write_data,
    output logic [NUM_REGS-1:0]   pending,
    output logic                  err_overflow
);
    localparam int PW = $clog2(FIFO_DEPTH);
    logic [SEL_WIDTH-1:0]  f_sel  [FIFO_DEPTH];
    logic [DATA_WIDTH-1:0] f_data [FIFO_DEPTH];
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [PW:0]           count;
    logic                  accept, pop, bypass, push, l_commit;
    logic [SEL_WIDTH-1:0]  commit_sel;
    logic [DATA_WIDTH-1:0] commit_data;
    logic [NUM_REGS-1:0]   ovf;

    assign l_ready = !rst && (count < (PW+1)'(FIFO_DEPTH));

    always_comb begin
        accept      = l_valid && l_ready;
        pop         = !a_valid && (count != '0);
`ifdef OPT_WB_L_BYPASS_EN
        bypass      = !a_valid && (count == '0) && accept;
`else
        bypass      = 1'b0;
`endif
        push        = accept && !bypass;
        l_commit    = pop || bypass;
        commit_sel  = pop ? f_sel[rd_ptr] : l_sel;
        commit_data = pop ? f_data[rd_ptr] : l_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            write_en     <= 1'b0;
            write_sel    <= '0;
            write_data   <= '0;
            wr_ptr       <= '0;
            rd_ptr       <= '0;
            count        <= '0;
            err_overflow <= 1'b0;
        end else begin
            write_en <= a_valid || l_commit;
            if (a_valid) begin
                write_sel  <= a_sel;
                write_data <= a_data;
            end else if (l_commit) begin
                write_sel  <= commit_sel;
                write_data <= commit_data;
            end
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
            if (|ovf) err_overflow <= 1'b1;
        end
    end

    // Storage needs no reset: the pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (push) begin
            f_sel[wr_ptr]  <= l_sel;
            f_data[wr_ptr] <= l_data;
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_sb
        logic [1:0] cnt;
        logic       inc, dec;
        assign inc        = (i != 0) && reserve_en && (reserve_sel == SEL_WIDTH'(i));
        assign dec        = l_commit && (commit_sel == SEL_WIDTH'(i));
        assign ovf[i]     = inc && !dec && (cnt == 2'd3);
        assign pending[i] = (cnt != 2'd0);
        always_ff @(posedge clk) begin
            if (rst) cnt <= 2'd0;
            else if (inc && !dec && cnt != 2'd3) cnt <= cnt + 2'd1;
            else if (dec && !inc && cnt != 2'd0) cnt <= cnt - 2'd1;
        end
    end
endmodule

// File: tb/tb_reg_file_writeback_arbiter.sv
// tb_reg_file_writeback_arbiter: directed stimulus with a write-port scoreboard for reg_file_writeback_arbiter.
module tb_reg_file_writeback_arbiter;
`ifdef OPT_WB_L_BYPASS_EN
    localparam int LAT = 1;
`else
    localparam int LAT = 2;
`endif
    logic        clk = 1'b0;
    logic        rst, a_valid, l_valid, l_ready, reserve_en, write_en, err_overflow;
    logic [3:0]  a_sel, l_sel, reserve_sel, write_sel;
    logic [31:0] a_data, l_data, write_data;
    logic [15:0] pending;
    int          cyc = 0;
    int          checks = 0;
    int          failures = 0;

    typedef struct {
        logic [3:0]  sel;
        logic [31:0] data;
        int          at;
    } exp_t;
    exp_t q[$];
    exp_t m;

    reg_file_writeback_arbiter dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_sel(a_sel), .a_data(a_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_sel(l_sel), .l_data(l_data),
        .reserve_en(reserve_en), .reserve_sel(reserve_sel),
        .write_en(write_en), .write_sel(write_sel), .write_data(write_data),
        .pending(pending), .err_overflow(err_overflow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h at cycle %0d", name, act, exp, cyc);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_wr(input logic [3:0] sel, input logic [31:0] data, input int at);
        q.push_back('{sel, data, at});
    endtask

    // Monitor: every visible write must match the head of the scoreboard.
    always @(negedge clk) begin
        if (!rst && write_en) begin
            if (q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write actual sel=%h data=%h required no write at cycle %0d", write_sel, write_data, cyc);
            end else begin
                m = q.pop_front();
                chk("wr_sel", 32'(write_sel), 32'(m.sel));
                chk("wr_data", write_data, m.data);
                if (m.at >= 0) chk("wr_cycle", 32'(cyc), 32'(m.at));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int k;
        int l_sels [6] = '{1, 2, 3, 3, 3, 3};
        int rdy_exp[6] = '{1, 1, 0, 0, 0, 1};
        rst = 1'b1; a_valid = 1'b1; a_sel = 4'd5; a_data = 32'h1;
        l_valid = 1'b1; l_sel = 4'd5; l_data = 32'h2;
        reserve_en = 1'b1; reserve_sel = 4'd5;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_write_en", 32'(write_en), 0);
            chk("rst_pending", 32'(pending), 0);
            chk("rst_l_ready", 32'(l_ready), 0);
            chk("rst_err", 32'(err_overflow), 0);
        end
        rst = 1'b0; a_valid = 1'b0; l_valid = 1'b0; reserve_en = 1'b0;
        #1;
        chk("post_rst_l_ready", 32'(l_ready), 1);

        a_valid = 1'b1; a_sel = 4'd3; a_data = 32'hDEADBEEF;
        expect_wr(4'd3, 32'hDEADBEEF, cyc + 1);
        step();
        a_valid = 1'b0;
        step();
        chk("a_write_clears", 32'(write_en), 0);

        reserve_en = 1'b1; reserve_sel = 4'd7;
        step();
        reserve_en = 1'b0;
        chk("pending_r7_set", 32'(pending), 32'h0080);
        l_valid = 1'b1; l_sel = 4'd7; l_data = 32'h12345678;
        chk("l_ready_idle", 32'(l_ready), 1);
        expect_wr(4'd7, 32'h12345678, cyc + LAT);
        step();
        l_valid = 1'b0;
        step();
        step();
        chk("pending_r7_clear", 32'(pending), 0);
        chk("l_write_clears", 32'(write_en), 0);

        k = cyc;
        for (int i = 0; i < 4; i++) expect_wr(4'(10 + i), 32'hA0 + 32'(i), k + 1 + i);
        expect_wr(4'd1, 32'h11, k + 5);
        expect_wr(4'd2, 32'h22, k + 6);
        expect_wr(4'd3, 32'h33, k + 7);
        for (int i = 0; i < 6; i++) begin
            a_valid = (i < 4); a_sel = 4'(10 + i); a_data = 32'hA0 + 32'(i);
            l_valid = 1'b1; l_sel = 4'(l_sels[i]); l_data = 32'h11 * 32'(l_sels[i]);
            chk("l_ready_backpressure", 32'(l_ready), 32'(rdy_exp[i]));
            step();
        end
        a_valid = 1'b0; l_valid = 1'b0;
        for (int i = 0; i < 3; i++) step();
        chk("collision_drained", 32'(write_en), 0);

        reserve_en = 1'b1; reserve_sel = 4'd9;
        step();
        l_valid = 1'b1; l_sel = 4'd9; l_data = 32'h99;
        expect_wr(4'd9, 32'h99, cyc + LAT);
        reserve_en = (LAT == 1);
        step();
        l_valid = 1'b0;
        reserve_en = (LAT == 2);
        step();
        reserve_en = 1'b0;
        chk("same_cycle_pending_r9", 32'(pending), 32'h0200);
        chk("same_cycle_err", 32'(err_overflow), 0);
        l_valid = 1'b1; l_sel = 4'd9; l_data = 32'h9A;
        expect_wr(4'd9, 32'h9A, cyc + LAT);
        step();
        l_valid = 1'b0;
        step();
        step();
        chk("pending_r9_clear", 32'(pending), 0);

        reserve_sel = 4'd4;
        for (int i = 0; i < 4; i++) begin
            reserve_en = 1'b1;
            step();
            chk("err_overflow", 32'(err_overflow), 32'(i == 3));
        end
        chk("pending_r4", 32'(pending), 32'h0010);
        reserve_sel = 4'd0;
        step();
        reserve_en = 1'b0;
        chk("pending_r0_ignored", 32'(pending), 32'h0010);
        l_valid = 1'b1; l_sel = 4'd0; l_data = 32'h55;
        expect_wr(4'd0, 32'h55, cyc + LAT);
        step();
        l_valid = 1'b0;
        step();
        step();
        chk("err_sticky", 32'(err_overflow), 1);
        chk("pending_after_r0", 32'(pending), 32'h0010);
        step();
        chk("scoreboard_empty", 32'(q.size()), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/reg_file_writeback_arbiter.md
Name: reg_file_writeback_arbiter

Overview:
- Writer-side counterpart of the 16 x 32-bit register file. The register file has a single synchronous write port (write_en, write_sel, write_data), and this block is the only driver of that port.
- Merges two result sources into that port:
  - pipeline results (port A): single-cycle, never stalled;
  - long-latency results from load/mul/div (port L): valid/ready handshake, buffered in a 2-entry FIFO.
- Keeps a per-register pending-write scoreboard so decode can stall on outstanding long-latency destinations.

Parameters:
- NUM_REGS, 16, number of architectural registers; index 0 is hard-wired zero.
- DATA_WIDTH, 32, register data width.
- SEL_WIDTH, 4, register select width, log2(NUM_REGS).
- FIFO_DEPTH, 2, entries in the port-L buffer; must be a power of 2.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- a_valid  in  1  pipeline result present this cycle
- a_sel  in  SEL_WIDTH  pipeline destination register
- a_data  in  DATA_WIDTH  pipeline result
- l_valid  in  1  long-latency result offered
- l_ready  out  1  long-latency result accepted when l_valid && l_ready
- l_sel  in  SEL_WIDTH  long-latency destination register
- l_data  in  DATA_WIDTH  long-latency result
- reserve_en  in  1  decode issued a long-latency op this cycle
- reserve_sel  in  SEL_WIDTH  its destination register
- write_en  out  1  to register file write_en
- write_sel  out  SEL_WIDTH  to register file write_sel
- write_data  out  DATA_WIDTH  to register file write_data
- pending  out  NUM_REGS  bit i set when register i has an outstanding long-latency write
- err_overflow  out  1  sticky: a reserve hit a saturated counter

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, rst.
- Reset state (rst high at posedge):
  - write_en=0, write_sel=0, write_data=0;
  - FIFO emptied;
  - all pending counters=0, so pending=0;
  - err_overflow=0;
  - l_ready=0 during the reset cycle.
- Reset mid-operation discards buffered L results and all reservations. Decode is flushed by the same reset.
- Write outputs are registered. Each cycle exactly one of the following happens, in priority order:
  1. a_valid=1: next cycle write_en=1, write_sel=a_sel, write_data=a_data. A latency = 1 cycle.
  2. else FIFO non-empty: pop the head; next cycle write_en=1 with the head's sel/data.
  3. else: write_en=0; write_sel and write_data hold their previous values.
- If the issuing sel is 0, write_en still drives 1. The register file ignores r0, so the block forwards writes to r0 unchanged.
- Port L handshake:
  - l_ready = !rst && (FIFO count < FIFO_DEPTH). It is combinational from registered state only, with no dependence on l_valid.
  - A push on a full FIFO cannot occur.
  - Push and pop in the same cycle are allowed; the count is unchanged.
  - FIFO pointers wrap modulo FIFO_DEPTH.
  - Without the optional feature, L latency is 2 cycles minimum (push, then pop), plus any cycles where A wins.
- Scoreboard: per-register 2-bit counter cnt[i]; pending[i] = (cnt[i] != 0).
  - Increment: reserve_en && reserve_sel==i && i!=0. If cnt[i]==3, hold at 3 and set err_overflow.
  - Decrement: when an L-sourced write issues to register i (the cycle it leaves the FIFO or bypasses), saturating at 0.
  - Increment and decrement to the same i in the same cycle: cnt unchanged.
  - reserve_sel=0 is ignored.
  - A-sourced writes never change counters.
  - pending[0] is always 0.
  - Counters and the pending output update at the posedge, so pending is a registered output.
- Ordering:
  - L results commit in acceptance order.
  - A results may overtake buffered L results. Decode must not issue an A write to a register whose pending bit is set; a violation is not detected.

Optional Feature:
- Macro OPT_WB_L_BYPASS_EN.
- Defined: if a_valid=0, the FIFO is empty, and l_valid && l_ready, the L result goes straight to the write registers without a push. L latency is 1 cycle, and the scoreboard decrement happens that same cycle.
- Undefined: every L result passes through the FIFO, giving a minimum L latency of 2 cycles.

Test Plan:
- Reset: hold rst 3 cycles with a_valid=1, l_valid=1, reserve_en=1 (sel 5) -> write_en=0, pending=0, l_ready=0, err_overflow=0 throughout; first post-reset cycle l_ready=1.
- Single A write: a_valid=1 a_sel=3 a_data=0xDEADBEEF for 1 cycle -> next cycle write_en=1, write_sel=3, write_data=0xDEADBEEF; following cycle write_en=0.
- Long-latency with scoreboard: reserve r7 -> pending[7]=1 next cycle; later L push sel=7 data=0x12345678 -> write on cycle+2 (cycle+1 with bypass); pending[7]=0 the cycle after that write.
- Collision/backpressure: a_valid=1 for 4 cycles while l_valid=1 continuously (sels 1,2,3) -> A writes issue every cycle; FIFO fills after 2 accepts and l_ready=0; after A stops, L writes sel 1 then 2 drain in order, then sel 3 is accepted.
- Same-cycle reserve and commit: cnt[9]=1, L write to r9 issuing while reserve_en sel=9 -> pending[9] stays 1, cnt[9]=1; the next L commit to r9 clears it.
- Overflow and r0: reserve r4 four times with no commits -> err_overflow=1 sticky, pending[4]=1; reserve r0 -> pending[0] stays 0; L write sel=0 -> write_en=1 write_sel=0.
